// File: rtl/pc_branch_update_pkg.sv
// pc_branch_update_pkg: shared encodings and constants for the PC update block
package pc_branch_update_pkg;

    typedef enum logic [1:0] {
        BR_EQ = 2'b00,
        BR_NE = 2'b01,
        BR_GT = 2'b10,
        BR_LE = 2'b11
    } br_op_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [1:0]  ALIGN_MASK   = 2'b11;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/pc_branch_update_sat_counter.sv
// sat_counter: saturating up-counter with clear taking priority over increment
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !(&cnt))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/pc_branch_update.sv
// pc_branch_update: architectural PC register with conditional-branch load,
// alignment fault flag and saturating branch statistics
module pc_branch_update
    import pc_branch_update_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
    parameter int          CNT_W       = 16,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      branch_cond,
    input  logic             pc_write,
    input  logic             pc_write_cond,
    input  logic [31:0]      pc_in,
    input  logic             stall,
    input  logic             clear_stats,
    output logic [31:0]      pc_out,
    output logic             branch_taken,
    output logic             align_err,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    logic cond, pc_en, misalign, pc_write_cond_q, br_evt, tk_evt;
    logic unused_cond_bits;

    assign cond             = branch_cond[0];
    assign unused_cond_bits = ^branch_cond[31:1];
    assign pc_en            = pc_write | (pc_write_cond & cond);
    assign misalign         = CHECK_ALIGN && is_misaligned(pc_in);
    // a held pc_write_cond level is one branch; pc_write overrides it as a plain jump
    assign br_evt           = pc_write_cond & ~pc_write_cond_q & ~stall;
    assign tk_evt           = br_evt & cond & ~misalign & ~pc_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_out          <= RESET_PC;
            branch_taken    <= 1'b0;
            align_err       <= 1'b0;
            pc_write_cond_q <= 1'b0;
        end else begin
            if (pc_en && !stall && !misalign)
                pc_out <= pc_in;
            if (pc_en && !stall && misalign)
                align_err <= 1'b1;
            branch_taken <= tk_evt;
            if (!stall)
                pc_write_cond_q <= pc_write_cond;
        end
    end

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (br_evt),
        .clr   (clear_stats),
        .cnt   (br_count)
    );

    sat_counter #(.W(CNT_W)) u_tk_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (tk_evt),
        .clr   (clear_stats),
        .cnt   (taken_count)
    );

endmodule

// File: tb/tb_pc_branch_update.sv
// tb_pc_branch_update: directed checks of PC load, branch events, alignment and counters
module tb_pc_branch_update;

    logic        clk, reset, pc_write, pc_write_cond, stall, clear_stats;
    logic [31:0] branch_cond, pc_in;
    logic [31:0] pc0, pc1, pc2;
    logic        bt0, bt1, bt2, ae0, ae1, ae2;
    logic [15:0] brc0, tkc0, brc1, tkc1;
    logic [1:0]  brc2, tkc2;
    int          tests = 0, failed = 0;

    pc_branch_update dut0 (
        .clk(clk), .reset(reset), .branch_cond(branch_cond), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .pc_in(pc_in), .stall(stall), .clear_stats(clear_stats),
        .pc_out(pc0), .branch_taken(bt0), .align_err(ae0), .br_count(brc0), .taken_count(tkc0)
    );

    pc_branch_update #(.CHECK_ALIGN(1'b0)) dut1 (
        .clk(clk), .reset(reset), .branch_cond(branch_cond), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .pc_in(pc_in), .stall(stall), .clear_stats(clear_stats),
        .pc_out(pc1), .branch_taken(bt1), .align_err(ae1), .br_count(brc1), .taken_count(tkc1)
    );

    pc_branch_update #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .branch_cond(branch_cond), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .pc_in(pc_in), .stall(stall), .clear_stats(clear_stats),
        .pc_out(pc2), .branch_taken(bt2), .align_err(ae2), .br_count(brc2), .taken_count(tkc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; pc_write = 0; pc_write_cond = 0; stall = 0; clear_stats = 0;
        branch_cond = 32'h0; pc_in = 32'h0;
        tick(); tick();
        reset = 1'b0;
        tick();
        tests++; if (pc0 !== 32'h0) begin failed++; $display("FAIL reset_pc got %h want %h", pc0, 32'h0); end
        tests++; if (bt0 !== 1'b0 || ae0 !== 1'b0) begin failed++; $display("FAIL reset_flags got bt=%b ae=%b want 0 0", bt0, ae0); end
        tests++; if (brc0 !== 16'd0 || tkc0 !== 16'd0) begin failed++; $display("FAIL reset_counts got %0d %0d want 0 0", brc0, tkc0); end
    endtask

    task automatic test_pc_write();
        pc_write = 1; pc_in = 32'h4;
        tick();
        pc_write = 0;
        tests++; if (pc0 !== 32'h4) begin failed++; $display("FAIL pc_write got %h want %h", pc0, 32'h4); end
        tests++; if (brc0 !== 16'd0 || bt0 !== 1'b0) begin failed++; $display("FAIL pc_write_side got brc=%0d bt=%b want 0 0", brc0, bt0); end
    endtask

    task automatic test_taken();
        pc_write_cond = 1; branch_cond = 32'h1; pc_in = 32'h40;
        tick();
        pc_write_cond = 0;
        tests++; if (pc0 !== 32'h40) begin failed++; $display("FAIL taken_pc got %h want %h", pc0, 32'h40); end
        tests++; if (bt0 !== 1'b1) begin failed++; $display("FAIL taken_pulse got %b want 1", bt0); end
        tests++; if (brc0 !== 16'd1 || tkc0 !== 16'd1) begin failed++; $display("FAIL taken_counts got %0d %0d want 1 1", brc0, tkc0); end
        tick();
        tests++; if (bt0 !== 1'b0) begin failed++; $display("FAIL taken_pulse_end got %b want 0", bt0); end
    endtask

    task automatic test_not_taken();
        pc_write_cond = 1; branch_cond = 32'hFFFF_FFFE; pc_in = 32'h80;
        tick();
        tests++; if (bt0 !== 1'b0) begin failed++; $display("FAIL not_taken_pulse got %b want 0", bt0); end
        tick(); tick();
        pc_write_cond = 0;
        tick();
        tests++; if (pc0 !== 32'h40) begin failed++; $display("FAIL not_taken_pc got %h want %h", pc0, 32'h40); end
        tests++; if (brc0 !== 16'd2 || tkc0 !== 16'd1) begin failed++; $display("FAIL not_taken_counts got %0d %0d want 2 1", brc0, tkc0); end
    endtask

    task automatic test_misalign();
        pc_write = 1; pc_in = 32'h42;
        tick();
        pc_write = 0;
        tests++; if (pc0 !== 32'h40 || ae0 !== 1'b1) begin failed++; $display("FAIL misalign got pc=%h ae=%b want 00000040 1", pc0, ae0); end
        tests++; if (pc1 !== 32'h42 || ae1 !== 1'b0) begin failed++; $display("FAIL no_check got pc=%h ae=%b want 00000042 0", pc1, ae1); end
        tick(); tick();
        tests++; if (ae0 !== 1'b1) begin failed++; $display("FAIL align_sticky got %b want 1", ae0); end
    endtask

    task automatic test_stall();
        stall = 1; pc_write = 1; pc_in = 32'h100;
        tick(); tick();
        tests++; if (pc0 !== 32'h40) begin failed++; $display("FAIL stall_hold got %h want %h", pc0, 32'h40); end
        stall = 0;
        tick();
        pc_write = 0;
        tests++; if (pc0 !== 32'h100) begin failed++; $display("FAIL stall_release got %h want %h", pc0, 32'h100); end
    endtask

    task automatic test_write_dominates();
        pc_write = 1; pc_write_cond = 1; branch_cond = 32'h0; pc_in = 32'h200;
        tick();
        pc_write = 0; pc_write_cond = 0;
        tests++; if (pc0 !== 32'h200 || bt0 !== 1'b0) begin failed++; $display("FAIL dominate got pc=%h bt=%b want 00000200 0", pc0, bt0); end
        tests++; if (brc0 !== 16'd3 || tkc0 !== 16'd1) begin failed++; $display("FAIL dominate_counts got %0d %0d want 3 1", brc0, tkc0); end
        tick();
    endtask

    task automatic test_counters();
        stall = 1; clear_stats = 1;
        tick();
        stall = 0; clear_stats = 0;
        tests++; if (brc0 !== 16'd0 || tkc0 !== 16'd0 || brc2 !== 2'd0) begin failed++; $display("FAIL clear_in_stall got %0d %0d %0d want 0 0 0", brc0, tkc0, brc2); end
        branch_cond = 32'h1; pc_in = 32'h300;
        for (int i = 0; i < 5; i++) begin
            pc_write_cond = 1; tick();
            pc_write_cond = 0; tick();
        end
        tests++; if (brc0 !== 16'd5 || tkc0 !== 16'd5) begin failed++; $display("FAIL count5 got %0d %0d want 5 5", brc0, tkc0); end
        tests++; if (brc2 !== 2'd3 || tkc2 !== 2'd3) begin failed++; $display("FAIL saturate got %0d %0d want 3 3", brc2, tkc2); end
        pc_write_cond = 1; clear_stats = 1;
        tick();
        pc_write_cond = 0; clear_stats = 0;
        tests++; if (brc0 !== 16'd0 || tkc0 !== 16'd0 || brc2 !== 2'd0) begin failed++; $display("FAIL clear_wins got %0d %0d %0d want 0 0 0", brc0, tkc0, brc2); end
        tests++; if (bt0 !== 1'b1) begin failed++; $display("FAIL clear_pulse got %b want 1", bt0); end
        tick();
    endtask

    task automatic test_async_reset();
        pc_write = 1; pc_in = 32'h500;
        tick();
        pc_write = 0;
        tests++; if (pc0 !== 32'h500 || ae0 !== 1'b1) begin failed++; $display("FAIL pre_reset got pc=%h ae=%b want 00000500 1", pc0, ae0); end
        #2 reset = 1;
        #1;
        tests++; if (pc0 !== 32'h0 || ae0 !== 1'b0 || bt0 !== 1'b0) begin failed++; $display("FAIL async_reset got pc=%h ae=%b bt=%b want 0 0 0", pc0, ae0, bt0); end
        tick();
        reset = 0;
        tick();
        tests++; if (pc0 !== 32'h0 || brc0 !== 16'd0) begin failed++; $display("FAIL post_reset got pc=%h brc=%0d want 0 0", pc0, brc0); end
    endtask

    initial begin
        test_reset();
        test_pc_write();
        test_taken();
        test_not_taken();
        test_misalign();
        test_stall();
        test_write_dominates();
        test_counters();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
